multi_port_comparator: RTL and testbench

//  Parametrised successor to the single-port comparator in the packet-sniffer datapath.

---
 rtl/multi_port_comparator.sv | 122 ++++++++++++
 tb/tb_multi_port_comparator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_comparator.sv
// multi_port_comparator
//   Scans a 32-bit byte stream against NUM_PORTS flagged 16-bit port numbers.
//   It checks every byte alignment, including the pair that straddles two
//   consecutive valid words. Any hit sets a sticky per-channel flag. The data
//   is forwarded unchanged through a DELAY-stage pipeline.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active-high; takes priority over everything
//   clear          in   synchronous clear of the history byte and the sticky mask
//   data_valid     in   data_in carries a valid word this cycle
//   data_in        in   [31:0] stream word; [31:24] is the first byte on the wire
//   flagged_ports  in   [16*NUM_PORTS-1:0]; port i = flagged_ports[16*i +: 16]
//   port_enable    in   [NUM_PORTS-1:0]; 1 = channel i participates
//   data_out       out  [31:0] data_in delayed DELAY cycles; 0 when not valid
//   data_out_valid out  data_valid delayed DELAY cycles
//   match          out  OR of match_mask
//   match_mask     out  [NUM_PORTS-1:0] sticky per-channel hit flags
//   match_id       out  [2:0] lowest set index in match_mask; 0 when none set
//
// Handshake: there is no back-pressure. A word is accepted on every rising
//   edge where data_valid=1. data_out/data_out_valid present it exactly DELAY
//   edges later, and the consumer must take it in that cycle.
module multi_port_comparator #(
  parameter int NUM_PORTS = 4,
  parameter int DELAY     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      data_valid,
  input  logic [31:0]               data_in,
  input  logic [16*NUM_PORTS-1:0]   flagged_ports,
  input  logic [NUM_PORTS-1:0]      port_enable,
  output logic [31:0]               data_out,
  output logic                      data_out_valid,
  output logic                      match,
  output logic [NUM_PORTS-1:0]      match_mask,
  output logic [2:0]                match_id
);

  // Only the last byte of the previous valid word can take part in a
  // straddling pair, so only that byte is kept as history.
  logic [7:0]           prev_byte;
  logic [15:0]          cand [4];
  logic [NUM_PORTS-1:0] hit;

  logic [31:0]          pipe_data [DELAY];
  logic [DELAY-1:0]     pipe_valid;

  // Four candidate 16-bit fields. Together with the straddle field, every
  // byte pair of the stream is examined exactly once.
  always_comb begin
    cand[0] = {prev_byte, data_in[31:24]};
    cand[1] = data_in[31:16];
    cand[2] = data_in[23:8];
    cand[3] = data_in[15:0];
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_valid && port_enable[i] &&
          ((cand[0] == flagged_ports[16*i +: 16]) ||
           (cand[1] == flagged_ports[16*i +: 16]) ||
           (cand[2] == flagged_ports[16*i +: 16]) ||
           (cand[3] == flagged_ports[16*i +: 16]))) begin
        hit[i] = 1'b1;
      end
    end
  end

  // History and sticky mask. A clear discards any hit in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_byte  <= '0;
      match_mask <= '0;
    end else if (clear) begin
      prev_byte  <= '0;
      match_mask <= '0;
    end else begin
      if (data_valid) begin
        prev_byte <= data_in[7:0];
      end
      match_mask <= match_mask | hit;
    end
  end

  // The data pipeline advances every cycle and ignores clear. Invalid words
  // are stored as zero, so data_out is 0 whenever data_out_valid is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int k = 0; k < DELAY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_valid[0] <= data_valid;
      pipe_data[0]  <= data_valid ? data_in : 32'h0;
      for (int k = 1; k < DELAY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_data[k]  <= pipe_data[k-1];
      end
    end
  end

  assign data_out       = pipe_data[DELAY-1];
  assign data_out_valid = pipe_valid[DELAY-1];
  assign match          = |match_mask;

  // Priority encode of the registered mask. The downward scan means the
  // lowest set index is the one that remains.
  always_comb begin
    match_id = 3'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (match_mask[i]) begin
        match_id = 3'(i);
      end
    end
  end

endmodule

// File: tb/tb_multi_port_comparator.sv
// tb_multi_port_comparator
//   Directed-vector bench for multi_port_comparator (NUM_PORTS=4, DELAY=3).
//   The driver pushes hand-computed expectations into queues. A monitor
//   pops and compares them after every rising edge.
module tb_multi_port_comparator;

  localparam int NUM_PORTS = 4;
  localparam int DELAY     = 3;

  logic                    clk;
  logic                    rst;
  logic                    clear;
  logic                    data_valid;
  logic [31:0]             data_in;
  logic [16*NUM_PORTS-1:0] flagged_ports;
  logic [NUM_PORTS-1:0]    port_enable;
  logic [31:0]             data_out;
  logic                    data_out_valid;
  logic                    match;
  logic [NUM_PORTS-1:0]    match_mask;
  logic [2:0]              match_id;

  multi_port_comparator #(.NUM_PORTS(NUM_PORTS), .DELAY(DELAY)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .flagged_ports  (flagged_ports),
    .port_enable    (port_enable),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .match          (match),
    .match_mask     (match_mask),
    .match_id       (match_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [6:0]  exp_mask_q[$];   // {mask[3:0], id[2:0]} expected after an edge
  int          errors = 0;
  int          checks = 0;

  logic [6:0]  m_exp;
  logic [31:0] d_exp;
  int          c_exp;

  always @(posedge clk) begin
    #1;
    if (exp_mask_q.size() > 0) begin
      m_exp = exp_mask_q.pop_front();
      checks++;
      if (match_mask !== m_exp[6:3]) begin
        errors++;
        $display("FAIL mask @%0d: got %b want %b", cyc, match_mask, m_exp[6:3]);
      end
      checks++;
      if (match !== (m_exp[6:3] != 4'b0)) begin
        errors++;
        $display("FAIL match @%0d: got %b want %b", cyc, match, (m_exp[6:3] != 4'b0));
      end
      checks++;
      if (match_id !== m_exp[2:0]) begin
        errors++;
        $display("FAIL match_id @%0d: got %0d want %0d", cyc, match_id, m_exp[2:0]);
      end
    end
    if (data_out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected @%0d: got %h want no valid output", cyc, data_out);
      end else begin
        d_exp = exp_q.pop_front();
        c_exp = exp_cyc_q.pop_front();
        if (data_out !== d_exp || cyc != c_exp) begin
          errors++;
          $display("FAIL data_out @%0d: got %h want %h at cycle %0d", cyc, data_out, d_exp, c_exp);
        end
      end
    end else begin
      checks++;
      if (data_out !== 32'h0 || data_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL data_idle @%0d: got valid=%b data=%h want 0/0", cyc, data_out_valid, data_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [31:0] d, input logic [3:0] en,
                      input logic [3:0] m, input logic [2:0] id);
    @(negedge clk);
    rst         = r;
    clear       = c;
    data_valid  = v;
    data_in     = d;
    port_enable = en;
    exp_mask_q.push_back({m, id});
    if (!r && v) begin
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc + DELAY);
    end
  endtask

  task automatic set_port(input int idx, input logic [15:0] val);
    flagged_ports[16*idx +: 16] = val;
  endtask

  task automatic idle(input int n, input logic [3:0] en,
                      input logic [3:0] m, input logic [2:0] id);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, en, m, id);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    data_valid    = 1'b0;
    data_in       = 32'h0;
    port_enable   = '0;
    flagged_ports = '0;
    set_port(0, 16'hABCD);
    set_port(1, 16'h0000);
    set_port(2, 16'h5678);
    set_port(3, 16'h9999);

    // Reset held two cycles with a valid all-ones word, then one quiet cycle.
    step(1, 0, 1, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 3'd0);
    step(1, 0, 1, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 0, 32'h0,         4'b0000, 4'b0000, 3'd0);

    // Aligned hit in the middle of a word, then sticky across idle cycles.
    step(0, 0, 1, 32'h00AB_CD00, 4'b0001, 4'b0001, 3'd0);
    idle(3, 4'b0001, 4'b0001, 3'd0);
    step(0, 0, 1, 32'h00AB_CD00, 4'b0001, 4'b0001, 3'd0);   // re-hit must not toggle
    step(0, 1, 0, 32'h0,         4'b0001, 4'b0000, 3'd0);   // clear

    // Straddle across consecutive words, then across an invalid gap.
    step(0, 0, 1, 32'h0000_00AB, 4'b0001, 4'b0000, 3'd0);
    step(0, 0, 1, 32'hCD00_0000, 4'b0001, 4'b0001, 3'd0);
    step(0, 1, 0, 32'h0,         4'b0001, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0000_00AB, 4'b0001, 4'b0000, 3'd0);
    step(0, 0, 0, 32'h0,         4'b0001, 4'b0000, 3'd0);
    step(0, 0, 1, 32'hCD00_0000, 4'b0001, 4'b0001, 3'd0);
    step(0, 1, 0, 32'h0,         4'b0001, 4'b0000, 3'd0);

    // Multi-channel hits and the priority encode.
    set_port(0, 16'h1234);
    step(0, 0, 1, 32'h1234_5678, 4'b0101, 4'b0101, 3'd0);
    step(0, 1, 0, 32'h0,         4'b0101, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0000_5678, 4'b0101, 4'b0100, 3'd2);
    step(0, 1, 0, 32'h0,         4'b0101, 4'b0000, 3'd0);

    // Clear beats a same-cycle hit and wipes history, so no straddle forms.
    set_port(0, 16'hABCD);
    step(0, 1, 1, 32'h0000_ABCD, 4'b0001, 4'b0000, 3'd0);
    step(0, 1, 1, 32'h0000_00AB, 4'b0001, 4'b0000, 3'd0);
    step(0, 0, 1, 32'hCD00_0000, 4'b0001, 4'b0000, 3'd0);

    // Zero port: disabled, it ignores zero words. Enabled, it hits.
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0000, 3'd0);
    step(0, 0, 0, 32'h0, 4'b0010, 4'b0000, 3'd0);   // enabled but no valid word
    step(0, 0, 1, 32'h0, 4'b0010, 4'b0010, 3'd1);
    step(0, 0, 1, 32'h0, 4'b0000, 4'b0010, 3'd1);   // disabling keeps the bit

    // Two channels hit in one word: 0x9999 (port3) and 0x0000 (port1).
    step(0, 0, 1, 32'h9999_0000, 4'b1111, 4'b1010, 3'd1);

    // Drain the pipe, then reset mid-run with a valid word present.
    idle(DELAY, 4'b1111, 4'b1010, 3'd1);
    step(1, 0, 1, 32'hFFFF_FFFF, 4'b1111, 4'b0000, 3'd0);
    step(0, 0, 0, 32'h0,         4'b1111, 4'b0000, 3'd0);
    step(0, 0, 1, 32'h5678_0000, 4'b0100, 4'b0100, 3'd2);
    idle(DELAY + 1, 4'b0000, 4'b0100, 3'd2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || exp_mask_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d data / %0d mask entries left want 0/0",
               exp_q.size(), exp_mask_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
